// File: rtl/kp_defs.sv
// kp_defs: shared state encoding, widths and helpers for the keypad scan controller.
package kp_defs;

   localparam int KEY_W = 4;
   localparam int ROW_W = 4;
   localparam int COL_W = 2;

   // All rows released (row lines are active low)
   localparam logic [ROW_W-1:0] ROWS_IDLE = 4'hF;

   typedef enum logic [1:0] {
      S_SCAN = 2'd0,
      S_DEB  = 2'd1,
      S_REL  = 2'd2
   } state_t;

   // Index of the lowest-numbered pressed (0) row; lowest index wins on multi-row presses
   function automatic logic [1:0] row_index(input logic [ROW_W-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = ROW_W - 1; i >= 0; i--) begin
         if (!rows[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/kp_debounce.sv
// kp_debounce: two-flop row synchronizer plus a stability counter compared against a reference pattern.
module kp_debounce
   import kp_defs::*;
#(
   parameter int DEB_CNT = 8
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [ROW_W-1:0] rows,
   input  logic [ROW_W-1:0] ref_rows,
   input  logic             run,
   input  logic             clr,
   output logic [ROW_W-1:0] rs,
   output logic             stable
);

   localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

   logic [ROW_W-1:0] meta_reg;
   logic [ROW_W-1:0] rs_reg;
   logic [DEB_W-1:0] deb_reg;
   logic             match;

   assign rs     = rs_reg;
   assign match  = (rs_reg == ref_rows);
   // Stable once the pattern has matched for DEB_CNT consecutive cycles (counter reads DEB_CNT-1 on the last one)
   assign stable = run && match && (deb_reg == DEB_LAST);

   // Bring the asynchronous row lines into the clock domain; idle value is all released
   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= ROWS_IDLE;
         rs_reg   <= ROWS_IDLE;
      end else begin
         meta_reg <= rows;
         rs_reg   <= meta_reg;
      end
   end

   // Count consecutive matching cycles; a mismatch or a completed run restarts the count
   always_ff @(posedge clk) begin
      if (srst || clr) begin
         deb_reg <= '0;
      end else if (run) begin
         if (!match || stable) begin
            deb_reg <= '0;
         end else begin
            deb_reg <= deb_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/kp_scan_ctrl.sv
// kp_scan_ctrl: paces the column scanner, freezes it on a key press, debounces, encodes
// the key and hands it out over VALID/ACK, then waits for release before scanning on.
module kp_scan_ctrl
   import kp_defs::*;
#(
   parameter int SCAN_DIV = 16,
   parameter int DEB_CNT  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [ROW_W-1:0] ROWS,
   input  logic [COL_W-1:0] COL,
   output logic             SCAN_EN,
   output logic [KEY_W-1:0] KEY,
   output logic             VALID,
   input  logic             ACK,
   output logic             OVR
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   state_t           state_reg;
   logic [DIV_W-1:0] div_reg;
   logic [ROW_W-1:0] cap_rows_reg;
   logic [COL_W-1:0] cap_col_reg;
   logic [KEY_W-1:0] key_reg;
   logic             valid_reg;
   logic             ovr_reg;

   logic [ROW_W-1:0] rs;
   logic [ROW_W-1:0] deb_ref;
   logic             deb_run;
   logic             stable;
   logic             div_end;
   logic             load;

   assign div_end = (div_reg == DIV_LAST);

   // Press debounce compares against the captured pattern, release debounce against all-idle
   assign deb_ref = (state_reg == S_DEB) ? cap_rows_reg : ROWS_IDLE;
   assign deb_run = (state_reg == S_DEB) || (state_reg == S_REL);
   assign load    = (state_reg == S_DEB) && stable;

   kp_debounce #(
      .DEB_CNT (DEB_CNT)
   ) u_debounce (
      .clk      (CLK),
      .srst     (RST),
      .rows     (ROWS),
      .ref_rows (deb_ref),
      .run      (deb_run),
      .clr      (!deb_run),
      .rs       (rs),
      .stable   (stable)
   );

   // Advance only at the end of a column dwell with no key seen; decoded purely from flops
   assign SCAN_EN = (state_reg == S_SCAN) && div_end && (rs == ROWS_IDLE);

   assign KEY   = key_reg;
   assign VALID = valid_reg;
   assign OVR   = ovr_reg;

   // Scan/debounce/release sequencing plus the key-code handshake
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= S_SCAN;
         div_reg      <= '0;
         cap_rows_reg <= ROWS_IDLE;
         cap_col_reg  <= '0;
         key_reg      <= '0;
         valid_reg    <= 1'b0;
         ovr_reg      <= 1'b0;
      end else begin
         case (state_reg)
            S_SCAN: begin
               if (div_end) begin
                  div_reg <= '0;
                  if (rs != ROWS_IDLE) begin
                     cap_rows_reg <= rs;
                     cap_col_reg  <= COL;
                     state_reg    <= S_DEB;
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            S_DEB: begin
               if (rs != cap_rows_reg) begin
                  // Bounce: rescan the same column from a fresh dwell
                  state_reg <= S_SCAN;
                  div_reg   <= '0;
               end else if (stable) begin
                  state_reg <= S_REL;
               end
            end
            S_REL: begin
               if (stable) begin
                  state_reg <= S_SCAN;
                  div_reg   <= '0;
               end
            end
            default: begin
               state_reg <= S_SCAN;
               div_reg   <= '0;
            end
         endcase

         // A load always wins over an acknowledge in the same cycle
         if (load) begin
            key_reg   <= {row_index(cap_rows_reg), cap_col_reg};
            valid_reg <= 1'b1;
            if (valid_reg && !ACK) begin
               ovr_reg <= 1'b1;
            end else if (valid_reg && ACK) begin
               ovr_reg <= 1'b0;
            end
         end else if (valid_reg && ACK) begin
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// tb_kp_scan_ctrl: keypad + column-scanner model around kp_scan_ctrl with a key/handshake reference model.
module tb_kp_scan_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int DEB_CNT  = 3;
   // Column entry -> rows seen by the dwell end (SCAN_DIV) -> press qualified (DEB_CNT)
   localparam int LOAD_LAT = SCAN_DIV + DEB_CNT;
   // Release -> 2 sync stages -> DEB_CNT idle cycles -> a full dwell to the next pulse
   localparam int REL_LAT  = 2 + DEB_CNT + SCAN_DIV - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ack = 1'b0;
   logic [1:0] col_cnt = 2'd0;
   logic [3:0] rows;
   logic       scan_en;
   logic [3:0] key;
   logic       valid;
   logic       ovr;
   logic [3:0] keypad [4];

   int n_pass  = 0;
   int n_total = 0;

   // Reference model of the consumer-visible state
   logic       m_valid = 1'b0;
   logic       m_ovr   = 1'b0;
   logic [3:0] m_key   = 4'd0;

   always #5 clk = ~clk;

   // Keypad: each column presents its own active-low row pattern
   always_comb rows = keypad[col_cnt];

   // External column scanner counts on each EN pulse
   always @(posedge clk) begin
      if (scan_en === 1'b1) col_cnt <= col_cnt + 2'd1;
   end

   kp_scan_ctrl #(
      .SCAN_DIV (SCAN_DIV),
      .DEB_CNT  (DEB_CNT)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .ROWS    (rows),
      .COL     (col_cnt),
      .SCAN_EN (scan_en),
      .KEY     (key),
      .VALID   (valid),
      .ACK     (ack),
      .OVR     (ovr)
   );

   // Key code: lowest pressed row index, then column
   function automatic logic [3:0] model_code(input logic [3:0] pat, input logic [1:0] c);
      int idx;
      idx = 0;
      while (idx < 3 && pat[idx]) idx++;
      return {idx[1:0], c};
   endfunction

   // Wait until the scanner steps onto column c (we are then in the first cycle of its dwell)
   task automatic wait_enter(input logic [1:0] c, output bit ok);
      logic [1:0] prev;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         prev = col_cnt;
         @(negedge clk);
         if (col_cnt == c && prev != c) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic press_key(input logic [3:0] pat, input logic [1:0] c, input bit ack_on_load);
      bit         ok;
      logic [3:0] code;
      code = model_code(pat, c);
      wait_enter(c, ok);
      n_total++;
      if (!ok) begin
         $display("FAIL enter_col: column %0d never reached within 200 cycles (got col %0d)", c, col_cnt);
         return;
      end
      n_pass++;
      keypad[c] = pat;
      for (int k = 1; k <= LOAD_LAT; k++) begin
         if (ack_on_load && k == LOAD_LAT) ack = 1'b1;
         @(negedge clk);
         if (k < LOAD_LAT) begin
            n_total++;
            if ({scan_en, valid, key} !== {1'b0, m_valid, m_key}) begin
               $display("FAIL press_hold k=%0d: got en=%b valid=%b key=%0d, expected en=0 valid=%b key=%0d",
                        k, scan_en, valid, key, m_valid, m_key);
            end else n_pass++;
         end
      end
      ack = 1'b0;
      if (m_valid && !ack_on_load) m_ovr = 1'b1;
      else if (m_valid && ack_on_load) m_ovr = 1'b0;
      m_valid = 1'b1;
      m_key   = code;
      n_total++;
      if ({valid, ovr, key, col_cnt} !== {m_valid, m_ovr, m_key, c}) begin
         $display("FAIL key_load pat=%b col=%0d ack=%0d: got valid=%b ovr=%b key=%0d col=%0d, expected valid=%b ovr=%b key=%0d col=%0d",
                  pat, c, ack_on_load, valid, ovr, key, col_cnt, m_valid, m_ovr, m_key, c);
      end else n_pass++;
      $display("press pat=%b col=%0d ack_on_load=%0d -> key=%0d valid=%b ovr=%b", pat, c, ack_on_load, key, valid, ovr);
   endtask

   task automatic release_key(input logic [1:0] c);
      keypad[c] = 4'hF;
      for (int k = 1; k <= REL_LAT; k++) begin
         @(negedge clk);
         n_total++;
         if ({scan_en, valid, ovr, key} !== {(k == REL_LAT), m_valid, m_ovr, m_key}) begin
            $display("FAIL release k=%0d: got en=%b valid=%b ovr=%b key=%0d, expected en=%b valid=%b ovr=%b key=%0d",
                     k, scan_en, valid, ovr, key, (k == REL_LAT), m_valid, m_ovr, m_key);
         end else n_pass++;
      end
      $display("release col=%0d -> scan resumed", c);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      n_total++;
      if ({valid, ovr, key} !== {m_valid, m_ovr, m_key}) begin
         $display("FAIL ack: got valid=%b ovr=%b key=%0d, expected valid=%b ovr=%b key=%0d",
                  valid, ovr, key, m_valid, m_ovr, m_key);
      end else n_pass++;
      $display("ack -> valid=%b ovr=%b key=%0d", valid, ovr, key);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({scan_en, key, valid, ovr} !== 7'd0) begin
         $display("FAIL reset: got en=%b key=%0d valid=%b ovr=%b, expected all 0", scan_en, key, valid, ovr);
      end else n_pass++;
      $display("reset -> en=%b key=%0d valid=%b ovr=%b", scan_en, key, valid, ovr);
      rst = 1'b0;
   endtask

   task automatic test_idle();
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         n_total++;
         if ({scan_en, valid, key} !== {(k % SCAN_DIV == SCAN_DIV - 1), 1'b0, 4'd0}) begin
            $display("FAIL idle k=%0d: got en=%b valid=%b key=%0d, expected en=%b valid=0 key=0",
                     k, scan_en, valid, key, (k % SCAN_DIV == SCAN_DIV - 1));
         end else n_pass++;
      end
      $display("idle scan 40 cycles checked");
   endtask

   task automatic test_clean_press();
      press_key(4'b1011, 2'd1, 1'b0);
      release_key(2'd1);
      ack_pulse();
   endtask

   task automatic test_bounce();
      bit ok;
      wait_enter(2'd1, ok);
      n_total++;
      if (!ok) $display("FAIL bounce_enter: column 1 never reached (got col %0d)", col_cnt);
      else n_pass++;
      for (int k = 0; k < 10; k++) begin
         keypad[1] = k[0] ? 4'b1011 : 4'hF;
         @(negedge clk);
         n_total++;
         if ({valid, key} !== {m_valid, m_key}) begin
            $display("FAIL bounce k=%0d: got valid=%b key=%0d, expected valid=%b key=%0d", k, valid, key, m_valid, m_key);
         end else n_pass++;
      end
      keypad[1] = 4'hF;
      $display("bounce 10 cycles -> valid=%b", valid);
      press_key(4'b1011, 2'd1, 1'b0);
      release_key(2'd1);
      ack_pulse();
   endtask

   task automatic test_overrun();
      press_key(4'b1110, 2'd0, 1'b0);
      release_key(2'd0);
      press_key(4'b0111, 2'd3, 1'b0);
      release_key(2'd3);
      ack_pulse();
      ack_pulse();   // acknowledge with nothing pending is ignored
   endtask

   task automatic test_back_to_back();
      logic [1:0] c;
      for (int i = 0; i < 3; i++) begin
         c = 2'($urandom_range(0, 3));
         press_key(4'($urandom_range(0, 14)), c, (i == 2));
         release_key(c);
      end
      ack_pulse();
   endtask

   task automatic test_reset_mid();
      bit         ok;
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      wait_enter(c, ok);
      n_total++;
      if (!ok) $display("FAIL rst_mid_enter: column %0d never reached", c);
      else n_pass++;
      keypad[c] = 4'($urandom_range(0, 14));
      repeat (SCAN_DIV + 1) @(negedge clk);   // one cycle into the press debounce
      rst = 1'b1;
      keypad[c] = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_key   = 4'd0;
      n_total++;
      if ({scan_en, key, valid, ovr} !== 7'd0) begin
         $display("FAIL rst_mid: got en=%b key=%0d valid=%b ovr=%b, expected all 0", scan_en, key, valid, ovr);
      end else n_pass++;
      $display("reset mid-debounce -> key=%0d valid=%b", key, valid);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n_total++;
         if (valid !== 1'b0) $display("FAIL rst_mid_novalid k=%0d: got valid=%b, expected 0", k, valid);
         else n_pass++;
      end
      press_key(4'b0101, 2'd2, 1'b0);
      release_key(2'd2);
      ack_pulse();
   endtask

   task automatic test_random();
      logic [1:0] c;
      for (int i = 0; i < 6; i++) begin
         c = 2'($urandom_range(0, 3));
         press_key(4'($urandom_range(0, 14)), c, 1'($urandom_range(0, 1)));
         release_key(c);
         if ($urandom_range(0, 1) == 1) ack_pulse();
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) keypad[i] = 4'hF;
      test_reset();
      test_idle();
      test_clean_press();
      test_bounce();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
